// File: rtl/dmem_pipe.sv
// dmem_pipe: single-port data memory with valid/ready requests, fixed-latency in-order responses,
// a sequential clear sweep and address range checking. Optional per-byte parity: DMEM_PARITY_EN.
module dmem_pipe #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  input  logic                  err_inject,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB = DATA_W / 8;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       cnt_nxt_s;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                accept_s;
  logic                in_range_s;
  logic [CW-1:0]       widx_s;
  logic [DATA_W-1:0]   st0_data_s;
  logic                st0_err_s;

  logic [READ_LAT-1:0] pv_r;
  logic [READ_LAT-1:0] pe_r;
  logic [DATA_W-1:0]   pd_r [READ_LAT];

`ifdef DMEM_PARITY_EN
  logic [NB-1:0]       par_r [DEPTH];

  // Even parity of every byte of a word, one bit per byte.
  function automatic logic [NB-1:0] byte_parity(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    p = '0;
    for (int b = 0; b < NB; b++) begin
      p[b] = ^d[8*b +: 8];
    end
    return p;
  endfunction
`else
  logic unused_err_inject_s;
  assign unused_err_inject_s = err_inject;
`endif

  // A request colliding with clear_req is held off so the sweep always starts clean.
  assign req_ready  = (state_r == ST_IDLE) && !clear_req;
  assign busy       = (state_r == ST_CLEAR);
  assign accept_s   = req_valid && req_ready;
  assign in_range_s = ({1'b0, req_addr} < DEPTH_A);
  assign widx_s     = req_addr[CW-1:0];

  // Sweep/idle state register and clear counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; clear_req during the sweep is ignored.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Array write port: sweep zeroes one word per cycle, otherwise byte-masked writes.
  always_ff @(posedge clk) begin
    if (state_r == ST_CLEAR) begin
      mem_r[cnt_r] <= '0;
`ifdef DMEM_PARITY_EN
      par_r[cnt_r] <= '0;
`endif
    end else if (accept_s && req_write && in_range_s) begin
      for (int b = 0; b < NB; b++) begin
        if (req_wstrb[b]) begin
          mem_r[widx_s][8*b +: 8] <= req_wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
          par_r[widx_s][b] <= (^req_wdata[8*b +: 8]) ^ ((b == 0) && err_inject);
`endif
        end
      end
    end
  end

  // First response stage contents: read data for in-range reads, zero otherwise.
  always_comb begin
    st0_data_s = '0;
    st0_err_s  = 1'b0;
    if (accept_s) begin
      if (!in_range_s) begin
        st0_data_s = '0;
        st0_err_s  = 1'b1;
      end else if (!req_write) begin
        st0_data_s = mem_r[widx_s];
`ifdef DMEM_PARITY_EN
        st0_err_s  = |(par_r[widx_s] ^ byte_parity(mem_r[widx_s]));
`else
        st0_err_s  = 1'b0;
`endif
      end else begin
        st0_data_s = '0;
        st0_err_s  = 1'b0;
      end
    end else begin
      st0_data_s = '0;
      st0_err_s  = 1'b0;
    end
  end

  // Response shift pipeline; empty slots carry zero data so outputs idle at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_r <= '0;
      pe_r <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pd_r[i] <= '0;
      end
    end else begin
      pv_r[0] <= accept_s;
      pe_r[0] <= st0_err_s;
      pd_r[0] <= st0_data_s;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_r[i] <= pv_r[i-1];
        pe_r[i] <= pe_r[i-1];
        pd_r[i] <= pd_r[i-1];
      end
    end
  end

  assign rsp_valid = pv_r[READ_LAT-1];
  assign rsp_err   = pe_r[READ_LAT-1];
  assign rsp_rdata = pd_r[READ_LAT-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed self-checking bench for dmem_pipe (DEPTH=32, READ_LAT=3).
module tb_dmem_pipe;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        err_inject;
  logic        clear_req;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;
  int n;

`ifdef DMEM_PARITY_EN
  localparam logic PAR_ERR = 1'b1;
`else
  localparam logic PAR_ERR = 1'b0;
`endif

  dmem_pipe #(.DATA_W(32), .DEPTH(32), .ADDR_W(8), .READ_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .err_inject(err_inject), .clear_req(clear_req),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request (called at posedge+1) and check its response LAT cycles later.
  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input logic inj,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wd; req_wstrb = ws; err_inject = inj;
    #1;
    chk({tag, "_ready"}, req_ready, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; err_inject = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk({tag, "_early"}, rsp_valid, 64'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_valid"}, rsp_valid, 64'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, rsp_err, exp_e);
    @(posedge clk); #1;
    chk({tag, "_single"}, rsp_valid, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'd0;
    req_wdata = 32'd0; req_wstrb = 4'd0; err_inject = 1'b0; clear_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 64'd1);
    chk("rst_ready", req_ready, 64'd0);
    chk("rst_valid", rsp_valid, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", rsp_err, 64'd0);

    // 1: initial sweep length, then a read of cleared memory
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("sweep_len", n, 64'd32);
    chk("ready_after_sweep", req_ready, 64'd1);
    do_req(1'b0, 8'd5, 32'd0, 4'h0, 1'b0, 32'd0, 1'b0, "rd5_init");

    // 2: byte-masked writes
    do_req(1'b1, 8'd3, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0, 1'b0, "wr3_full");
    do_req(1'b1, 8'd3, 32'h11223344, 4'h5, 1'b0, 32'd0, 1'b0, "wr3_mask");
    do_req(1'b0, 8'd3, 32'd0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0, "rd3");
    do_req(1'b1, 8'd3, 32'hFFFFFFFF, 4'h0, 1'b0, 32'd0, 1'b0, "wr3_nostrb");
    do_req(1'b0, 8'd3, 32'd0, 4'h0, 1'b0, 32'hDE22BE44, 1'b0, "rd3_again");

    // 3: back-to-back reads
    do_req(1'b1, 8'd0, 32'h0000000A, 4'hF, 1'b0, 32'd0, 1'b0, "pre0");
    do_req(1'b1, 8'd1, 32'h0000000B, 4'hF, 1'b0, 32'd0, 1'b0, "pre1");
    do_req(1'b1, 8'd2, 32'h0000000C, 4'hF, 1'b0, 32'd0, 1'b0, "pre2");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd0;
    @(posedge clk); #1;
    chk("b2b_c1_valid", rsp_valid, 64'd0);
    req_addr = 8'd1;
    @(posedge clk); #1;
    chk("b2b_c2_valid", rsp_valid, 64'd0);
    req_addr = 8'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_r0_valid", rsp_valid, 64'd1);
    chk("b2b_r0_data", rsp_rdata, 64'h0A);
    @(posedge clk); #1;
    chk("b2b_r1_valid", rsp_valid, 64'd1);
    chk("b2b_r1_data", rsp_rdata, 64'h0B);
    @(posedge clk); #1;
    chk("b2b_r2_valid", rsp_valid, 64'd1);
    chk("b2b_r2_data", rsp_rdata, 64'h0C);
    @(posedge clk); #1;
    chk("b2b_end_valid", rsp_valid, 64'd0);
    chk("b2b_end_data", rsp_rdata, 64'd0);

    // 4: out-of-range accesses
    do_req(1'b1, 8'd8, 32'h12345678, 4'hF, 1'b0, 32'd0, 1'b0, "wr8");
    do_req(1'b1, 8'd40, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0, 1'b1, "wr40_oor");
    do_req(1'b0, 8'd8, 32'd0, 4'h0, 1'b0, 32'h12345678, 1'b0, "rd8_alias");
    do_req(1'b0, 8'd32, 32'd0, 4'h0, 1'b0, 32'd0, 1'b1, "rd32_oor");
    do_req(1'b0, 8'd31, 32'd0, 4'h0, 1'b0, 32'd0, 1'b0, "rd31_edge");

    // 5: clear with a read in flight and a blocked request
    do_req(1'b1, 8'd7, 32'h55AA55AA, 4'hF, 1'b0, 32'd0, 1'b0, "wr7");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd7;
    #1;
    chk("inflight_ready", req_ready, 64'd1);
    @(posedge clk); #1;
    clear_req = 1'b1; req_addr = 8'd9;
    #1;
    chk("clr_block_ready", req_ready, 64'd0);
    @(posedge clk); #1;
    clear_req = 1'b0; req_valid = 1'b0;
    chk("clr_busy", busy, 64'd1);
    chk("clr_early_valid", rsp_valid, 64'd0);
    @(posedge clk); #1;
    chk("inflight_valid", rsp_valid, 64'd1);
    chk("inflight_data", rsp_rdata, 64'h55AA55AA);
    @(posedge clk); #1;
    chk("blocked_no_rsp", rsp_valid, 64'd0);
    n = 2;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("clr_sweep_len", n, 64'd32);
    for (int a = 0; a < 32; a++) begin
      do_req(1'b0, 8'(a), 32'd0, 4'h0, 1'b0, 32'd0, 1'b0, "clr_rd");
    end

    // 5b: reset during sweep restarts it; clear_req mid-sweep is ignored
    do_req(1'b1, 8'd31, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0, 1'b0, "wr31");
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("mid_sweep_busy", busy, 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 64'd1);
    chk("mid_rst_valid", rsp_valid, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      clear_req = (n == 5);
      @(posedge clk); #1;
    end
    clear_req = 1'b0;
    chk("restart_sweep_len", n, 64'd32);
    chk("restart_no_rsp", rsp_valid, 64'd0);
    do_req(1'b0, 8'd31, 32'd0, 4'h0, 1'b0, 32'd0, 1'b0, "rd31_cleared");

    // 6: parity error injection
    do_req(1'b1, 8'd2, 32'h000000FF, 4'h1, 1'b1, 32'd0, 1'b0, "wr2_inj");
    do_req(1'b0, 8'd2, 32'd0, 4'h0, 1'b0, 32'h000000FF, PAR_ERR, "rd2_inj");
    do_req(1'b1, 8'd2, 32'h000000FF, 4'h1, 1'b0, 32'd0, 1'b0, "wr2_fix");
    do_req(1'b0, 8'd2, 32'd0, 4'h0, 1'b0, 32'h000000FF, 1'b0, "rd2_fix");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised, synchronous, single-port data memory for the processor datapath.
- Takes a valid/ready request (read or byte-masked write) and returns an in-order response after a configurable fixed latency.
- Zeroes its contents with a sequential clear sweep after reset or on demand.
- Range-checks addresses against the configured depth.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
DEPTH, 32, number of words; power of 2, at least 2
ADDR_W, 8, request word-address width; 2^ADDR_W must be at least DEPTH
READ_LAT, 1, cycles from request acceptance to response; legal range 1..4

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request can be accepted this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_wstrb  in  DATA_W/8  byte write enables; bit i covers byte i
err_inject  in  1  parity error injection (used only with the optional feature)
clear_req  in  1  single-cycle request to re-zero the memory
busy  out  1  clear sweep in progress
rsp_valid  out  1  response valid, one cycle per accepted request
rsp_rdata  out  DATA_W  read data; 0 for writes and for errored accesses
rsp_err  out  1  response error flag

Behaviour:
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=CLEAR, clear counter=0. All pipeline valid bits cleared.
- Memory array itself is not reset; the clear sweep zeroes it.
- FSM has two states, CLEAR and IDLE.
- CLEAR:
  - Writes 0 (all bytes) to mem[cnt], cnt increments by 1 per cycle.
  - After writing word DEPTH-1: cnt returns to 0, FSM goes to IDLE.
  - Sweep takes exactly DEPTH cycles. busy=1 throughout.
- IDLE:
  - busy=0.
  - clear_req=1 goes to CLEAR on the next edge with cnt=0.
- req_ready = (FSM==IDLE) && !clear_req, combinational. A request arriving in the same cycle as clear_req is not accepted.
- Acceptance: req_valid && req_ready at a rising edge. Back-to-back acceptance allowed, one request per cycle.
- In range means req_addr < DEPTH.
- In-range write: byte i of mem[req_addr] updated iff req_wstrb[i]. req_wstrb=0 is a legal no-op write.
- Read: mem[req_addr] sampled at the acceptance edge.
  - A read of the address written on the immediately preceding acceptance returns the new data.
  - No same-cycle conflict is possible.
- Out of range (req_addr >= DEPTH): write dropped, memory unchanged; response has rsp_err=1 and rsp_rdata=0.
- Response pipeline:
  - Each accepted request produces exactly one response, with rsp_valid=1 for one cycle, READ_LAT cycles after the acceptance edge.
  - Responses are in acceptance order. There is no response backpressure.
  - READ_LAT=1: response is registered directly from the array read. READ_LAT>1: READ_LAT-1 further register stages follow.
  - rsp_rdata and rsp_err are 0 when rsp_valid=0.
- Responses already in flight when clear_req is taken still complete with their captured data.
- Reset mid-operation:
  - In-flight responses are discarded; no rsp_valid after reset.
  - A sweep in progress restarts at word 0.
  - Partially swept contents are not relied upon.
- clear_req while already in CLEAR: ignored; the sweep is not restarted.

Optional Feature:
- Macro: DMEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and written together with that byte. The clear sweep stores parity 0.
  - On an accepted write with err_inject=1, the stored parity of byte 0 is inverted, if byte 0 is written.
  - A read of any byte with a parity mismatch gives rsp_err=1; rsp_rdata still returns the stored data.
- Undefined:
  - No parity storage; err_inject is ignored.
  - rsp_err reports out-of-range only.
- Port list is identical in both builds.

Test Plan:
1. Deassert reset, DEPTH=32 -> busy=1 and req_ready=0 for exactly 32 cycles, then req_ready=1. Read addr 5 -> rsp_rdata=0, rsp_err=0, READ_LAT cycles after accept.
2. Write addr 3 data 0xDEADBEEF strobe 0xF, then write addr 3 data 0x11223344 strobe 0x5, then read addr 3 -> 0xDE22BE44. Three rsp_valid pulses in order; the writes return rdata 0.
3. READ_LAT=3, back-to-back reads of addr 0,1,2 (preloaded 0xA,0xB,0xC) on consecutive cycles -> rsp_valid on three consecutive cycles starting 3 cycles after the first accept, data 0xA,0xB,0xC.
4. Write addr 40 (DEPTH=32) data 0xFFFFFFFF -> rsp_err=1, rdata=0. Read addr 8 (40 mod 32) -> unchanged value.
5. Pulse clear_req with req_valid=1 and a read in flight -> request not accepted that cycle, in-flight response still delivered, busy=1 for 32 cycles, then every address reads 0. Assert reset at sweep cycle 10 -> sweep restarts, 32 more busy cycles.
6. With DMEM_PARITY_EN: write addr 2 data 0x000000FF strobe 0x1 with err_inject=1, then read addr 2 -> rsp_err=1, rsp_rdata=0x000000FF. Without the macro, the same sequence gives rsp_err=0.
